// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI responder.
package mcp3008_pkg;

  localparam int DATA_W     = 10;
  localparam int NUM_CH     = 8;
  localparam int CMD_BITS   = 4;
  localparam int TRAIL_BITS = 9;

  typedef logic [9:0] adc_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_NUL,
    ST_DATA,
    ST_TRAIL,
    ST_ZERO
  } state_t;

  // Differential pairs are adjacent even/odd channels; sel picks which side is positive.
  function automatic logic [5:0] diff_pair(input logic [2:0] sel);
    logic [2:0] pos;
    logic [2:0] neg;
    pos = sel;
    neg = sel ^ 3'b001;
    return {pos, neg};
  endfunction

endpackage

// File: rtl/mcp3008_responder_spi_in_sync.sv
// Multi-flop synchroniser plus edge detector for one asynchronous SPI input.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008 emulating SPI responder clocked entirely from clk.
// Define MCP3008_LSB_TRAILER_EN to append the LSB-first B1..B9 trailer after B0.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start bit (din=1 on a rise)
// ST_CMD   | shifting SGL/DIFF, D2, D1, D0
// ST_NUL   | next fall drives the null bit
// ST_DATA  | driving B9..B0 on falls
// ST_TRAIL | driving B1..B9 on falls (trailer build only)
// ST_ZERO  | driving zeros until cs_n rises
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     din,
  output logic                     dout,
  output logic                     dout_oe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     conv_valid,
  output logic                     conv_sgl,
  output logic [2:0]               conv_sel,
  output logic [DATA_W-1:0]        conv_result
);
  import mcp3008_pkg::*;

  if (NUM_CH != 8) begin : g_bad_num_ch
    $error("mcp3008_responder: NUM_CH must be 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mcp3008_responder: SYNC_STAGES must be at least 2");
  end

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic din_s, din_rise, din_fall;
  logic unused_edges;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_n), .level(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .pin(din), .level(din_s), .rise(din_rise), .fall(din_fall));

  assign unused_edges = &{1'b0, sclk_s, cs_rise, cs_fall, din_rise, din_fall};

  logic [DATA_W-1:0] ch_arr [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_arr[g] = ch_data[g*DATA_W +: DATA_W];
  end

  state_t             state;
  logic [3:0]         bit_cnt;
  logic [2:0]         cmd_sr;
  logic               armed;
  logic [FLUSH_W-1:0] flush_cnt;

  logic              new_sgl;
  logic [2:0]        new_sel;
  logic [5:0]        pair;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] new_result;

  // Result for the command completing on this rise; only consumed at the latch point.
  always_comb begin
    new_sgl = cmd_sr[2];
    new_sel = {cmd_sr[1:0], din_s};
    pair    = diff_pair(new_sel);
    diff    = {1'b0, ch_arr[pair[5:3]]} - {1'b0, ch_arr[pair[2:0]]};
    if (new_sgl)            new_result = ch_arr[new_sel];
    else if (diff[DATA_W])  new_result = '0;
    else                    new_result = diff[DATA_W-1:0];
  end

  // Armed only once cs_n is seen high after the synchronisers have flushed,
  // so a reset released mid-frame waits for the next cs_n fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      armed       <= 1'b0;
      flush_cnt   <= FLUSH_W'(SYNC_STAGES);
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_valid  <= 1'b0;
      conv_sgl    <= 1'b0;
      conv_sel    <= '0;
      conv_result <= '0;
    end else begin
      conv_valid <= 1'b0;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      if (cs_s) begin
        state   <= ST_IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
        if (flush_cnt == '0) armed <= 1'b1;
      end else if (armed) begin
        case (state)
          ST_IDLE: if (sclk_rise && din_s) begin
            state   <= ST_CMD;
            bit_cnt <= 4'(CMD_BITS - 1);
          end
          ST_CMD: if (sclk_rise) begin
            cmd_sr <= {cmd_sr[1:0], din_s};
            if (bit_cnt == '0) begin
              conv_valid  <= 1'b1;
              conv_sgl    <= new_sgl;
              conv_sel    <= new_sel;
              conv_result <= new_result;
              state       <= ST_NUL;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ST_NUL: if (sclk_fall) begin
            dout    <= 1'b0;
            dout_oe <= 1'b1;
            state   <= ST_DATA;
            bit_cnt <= 4'(DATA_W - 1);
          end
          ST_DATA: if (sclk_fall) begin
            dout <= conv_result[bit_cnt];
            if (bit_cnt == '0) begin
`ifdef MCP3008_LSB_TRAILER_EN
              state   <= ST_TRAIL;
              bit_cnt <= 4'(TRAIL_BITS - 1);
`else
              state   <= ST_ZERO;
`endif
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
`ifdef MCP3008_LSB_TRAILER_EN
          ST_TRAIL: if (sclk_fall) begin
            dout <= conv_result[4'(TRAIL_BITS) - bit_cnt];
            if (bit_cnt == '0) state <= ST_ZERO;
            else               bit_cnt <= bit_cnt - 1'b1;
          end
`endif
          ST_ZERO: if (sclk_fall) begin
            dout    <= 1'b0;
            dout_oe <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
